regfile_dumper: RTL and testbench
=================================

REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001: Parameter DATA_WIDTH, default 32, width of register words, ReadData, OutData and Checksum.
REQ-002: Parameter ADDR_WIDTH, default 5, register address width; the block SHALL walk a 2^ADDR_WIDTH-entry space (32 registers).
REQ-003: Clk  input  1  clock; all state SHALL update on the positive edge only.
REQ-004: Reset  input  1  synchronous, active-high reset, sampled on the Clk positive edge.
REQ-005: Start  input  1  request a dump; accepted only in IDLE.
REQ-006: Abort  input  1  terminate a dump in progress.
REQ-007: FirstReg  input  ADDR_WIDTH  first register address to dump.
REQ-008: LastReg  input  ADDR_WIDTH  last register address to dump, inclusive.
REQ-009: ReadRegister  output  ADDR_WIDTH  address driven to the register file asynchronous read port.
REQ-010: ReadData  input  DATA_WIDTH  asynchronous read data returned for ReadRegister.
REQ-011: OutData  output  DATA_WIDTH  dumped register word.
REQ-012: OutAddr  output  ADDR_WIDTH  register address of OutData.
REQ-013: OutValid  output  1  OutData/OutAddr valid.
REQ-014: OutReady  input  1  downstream accepts the word.
REQ-015: Busy  output  1  high in every state except IDLE.
REQ-016: Done  output  1  one-cycle pulse when a dump completes normally.
REQ-017: Checksum  output  DATA_WIDTH  XOR of all words accepted in the current/last dump.

Function
REQ-018: States SHALL be IDLE, FETCH, SEND and DONE, held in a registered state variable.
REQ-019: IDLE with Start=1 -> FETCH; the block SHALL latch FirstReg into an address register and LastReg into an end register, and clear Checksum to 0.
REQ-020: Start SHALL be ignored in every state other than IDLE; FirstReg/LastReg SHALL be sampled only at acceptance.
REQ-021: ReadRegister SHALL equal the address register in all states, with no combinational path from ReadData to ReadRegister.
REQ-022: FETCH SHALL last exactly one cycle; at its end OutData<=ReadData, OutAddr<=address, and the state moves to SEND.
REQ-023: In SEND, OutValid=1; OutValid SHALL be 0 in all other states.
REQ-024: While OutValid=1 and OutReady=0, OutData and OutAddr SHALL hold stable.
REQ-025: A handshake occurs on a cycle with OutValid=1 and OutReady=1; on it, Checksum <= Checksum XOR OutData.
REQ-026: On a handshake with address==end, next state SHALL be DONE; otherwise address <= address+1 modulo 2^ADDR_WIDTH and next state SHALL be FETCH.
REQ-027: A dump SHALL wrap around from 31 to 0 when FirstReg>LastReg and SHALL emit ((LastReg-FirstReg) mod 32)+1 words; FirstReg==LastReg SHALL emit exactly one word.
REQ-028: DONE SHALL assert Done=1 for exactly one cycle and then return to IDLE; Checksum SHALL hold its value until the next accepted Start.
REQ-029: Latency: first OutValid SHALL occur 2 cycles after the Start-accept edge; with OutReady held at 1, a word SHALL be emitted every 2 cycles.
REQ-030: Abort=1 in FETCH, SEND or DONE SHALL return the block to IDLE at the next edge with no Done pulse; a handshake in the same cycle SHALL still update Checksum.
REQ-031: Abort SHALL have priority over Start; Abort in IDLE SHALL have no effect.
REQ-032: The block SHALL never drive any register-file write signal; register 0 SHALL be dumped as whatever ReadData returns.

Reset
REQ-033: Reset=1 SHALL, at the next edge, force IDLE, OutValid=0, Busy=0, Done=0, Checksum=0, OutData=0, OutAddr=0, address=0, end=0, regardless of state.
REQ-034: Reset SHALL take priority over Abort and Start; a dump interrupted by Reset SHALL produce no further words and no Done pulse.

Verification
REQ-035: Regs r1..r3=0x11,0x22,0x44; Start with First=1, Last=3, OutReady=1 -> OutAddr 1,2,3, data 0x11,0x22,0x44 at cycles +2,+4,+6; Done at +7; Checksum=0x77.
REQ-036: First=30, Last=1 -> words from addresses 30,31,0,1 in order (4 words), then Done.
REQ-037: OutReady=0 for 5 cycles during the first SEND -> OutValid held high, OutData/OutAddr constant; word accepted once on OutReady=1.
REQ-038: Abort in SEND of the second word -> IDLE next cycle, Busy=0, no Done, Checksum equals the first word only.
REQ-039: Reset asserted mid-dump -> all outputs at reset values next cycle; a subsequent Start with First=Last=5 -> exactly one word from address 5, then Done.
REQ-040: Start pulsed while Busy -> ignored; the dump in progress completes with unchanged range.

Source files
------------

// File: rtl/regfile_dumper_if.sv
// Bus bundle for regfile_dumper: the dump control, the register-file read port
// and the output word stream.
interface regfile_dumper_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);

  // Dump control and status
  logic                  Start;
  logic                  Abort;
  logic [ADDR_WIDTH-1:0] FirstReg;
  logic [ADDR_WIDTH-1:0] LastReg;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] Checksum;

  // Register-file asynchronous read port
  logic [ADDR_WIDTH-1:0] ReadRegister;
  logic [DATA_WIDTH-1:0] ReadData;

  // Output word stream
  logic [DATA_WIDTH-1:0] OutData;
  logic [ADDR_WIDTH-1:0] OutAddr;
  logic                  OutValid;
  logic                  OutReady;

  // The dumper itself
  modport slave (
    input  Start, Abort, FirstReg, LastReg, ReadData, OutReady,
    output ReadRegister, OutData, OutAddr, OutValid, Busy, Done, Checksum
  );

  // Whoever drives the dumper and consumes its words
  modport master (
    output Start, Abort, FirstReg, LastReg, ReadData, OutReady,
    input  ReadRegister, OutData, OutAddr, OutValid, Busy, Done, Checksum
  );

endinterface

// File: rtl/regfile_dumper.sv
// Walks a register-file address range (wrapping modulo the address space),
// streams each word out over a valid/ready port and accumulates an XOR checksum
// of the accepted words.
module regfile_dumper #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input logic              Clk,
  input logic              Reset,
  regfile_dumper_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StSend,
    StDone
  } stateT;

  stateT                 stateQ, stateD;
  logic [ADDR_WIDTH-1:0] addrQ, addrD;
  logic [ADDR_WIDTH-1:0] endQ, endD;
  logic [DATA_WIDTH-1:0] outDataQ, outDataD;
  logic [ADDR_WIDTH-1:0] outAddrQ, outAddrD;
  logic [DATA_WIDTH-1:0] checksumQ, checksumD;
  logic                  handshake;

  // Next-state logic: sequencing, word capture and checksum accumulation
  always_comb begin
    stateD    = stateQ;
    addrD     = addrQ;
    endD      = endQ;
    outDataD  = outDataQ;
    outAddrD  = outAddrQ;
    checksumD = checksumQ;
    handshake = (stateQ == StSend) && bus.OutReady;

    case (stateQ)
      StIdle: begin
        // Abort outranks Start, so a simultaneous pair starts nothing
        if (bus.Start && !bus.Abort) begin
          stateD    = StFetch;
          addrD     = bus.FirstReg;
          endD      = bus.LastReg;
          checksumD = '0;
        end
      end
      StFetch: begin
        if (bus.Abort) begin
          stateD = StIdle;
        end else begin
          outDataD = bus.ReadData;
          outAddrD = addrQ;
          stateD   = StSend;
        end
      end
      StSend: begin
        // An accepted word always counts, even when aborted in the same cycle
        if (handshake) begin
          checksumD = checksumQ ^ outDataQ;
        end
        if (bus.Abort) begin
          stateD = StIdle;
        end else if (handshake) begin
          if (addrQ == endQ) begin
            stateD = StDone;
          end else begin
            addrD  = addrQ + ADDR_WIDTH'(1);
            stateD = StFetch;
          end
        end
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateQ    <= StIdle;
      addrQ     <= '0;
      endQ      <= '0;
      outDataQ  <= '0;
      outAddrQ  <= '0;
      checksumQ <= '0;
    end else begin
      stateQ    <= stateD;
      addrQ     <= addrD;
      endQ      <= endD;
      outDataQ  <= outDataD;
      outAddrQ  <= outAddrD;
      checksumQ <= checksumD;
    end
  end

  // Outputs come straight from registers; ReadData never reaches ReadRegister
  always_comb begin
    bus.ReadRegister = addrQ;
    bus.OutData      = outDataQ;
    bus.OutAddr      = outAddrQ;
    bus.OutValid     = (stateQ == StSend);
    bus.Busy         = (stateQ != StIdle);
    bus.Done         = (stateQ == StDone) && !bus.Abort;
    bus.Checksum     = checksumQ;
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// Self-checking bench for regfile_dumper: stimulus pushes the expected word
// sequence into a scoreboard queue, a negedge monitor pops and compares.
module tb_regfile_dumper;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int          NREG = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wordT;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  regfile_dumper_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_dumper #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Register file model behind the asynchronous read port
  logic [DW-1:0] regs [NREG];
  assign bus.ReadData = regs[bus.ReadRegister];

  wordT expQ[$];
  int   checks    = 0;
  int   failures  = 0;
  int   doneCount = 0;
  int   readyMode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Sole driver of OutReady, updated just after each active edge
  always @(posedge Clk) begin
    #2;
    case (readyMode)
      0:       bus.OutReady = 1'b1;
      1:       bus.OutReady = 1'($urandom_range(0, 1));
      default: bus.OutReady = 1'b0;
    endcase
  end

  // Monitor: scoreboard pops, hold-while-stalled and Done bookkeeping
  logic          prevValid = 1'b0, prevReady = 1'b0, prevAbort = 1'b0, prevReset = 1'b1;
  logic [DW-1:0] prevData;
  logic [AW-1:0] prevAddr;
  always @(negedge Clk) begin
    if (!Reset) begin
      if (prevValid && !prevReady && !prevAbort && !prevReset) begin
        check("hold_stable", {bus.OutValid, bus.OutAddr, bus.OutData},
              {1'b1, prevAddr, prevData});
      end
      if (bus.OutValid && bus.OutReady) begin
        if (expQ.size() == 0) begin
          check("unexpected_word", {bus.OutAddr, bus.OutData}, '0);
          failures += (bus.OutAddr == '0 && bus.OutData == '0) ? 1 : 0;
        end else begin
          wordT w;
          w = expQ.pop_front();
          check("word", {bus.OutAddr, bus.OutData}, {w.addr, w.data});
        end
      end
      if (bus.Done) begin
        doneCount++;
        check("done_words_left", expQ.size(), 0);
      end
    end
    prevValid = bus.OutValid;
    prevReady = bus.OutReady;
    prevAbort = bus.Abort;
    prevReset = Reset;
    prevData  = bus.OutData;
    prevAddr  = bus.OutAddr;
  end

  // Reference: words (first+i) mod 32 for i < ((last-first) mod 32)+1
  task automatic pushExp(input int first, input int last, output logic [DW-1:0] sum);
    int n;
    n   = (((last - first) % NREG) + NREG) % NREG + 1;
    sum = '0;
    for (int i = 0; i < n; i++) begin
      wordT w;
      w.addr = AW'((first + i) % NREG);
      w.data = regs[(first + i) % NREG];
      sum   ^= w.data;
      expQ.push_back(w);
    end
  endtask

  task automatic startDump(input int first, input int last, output logic [DW-1:0] sum);
    pushExp(first, last, sum);
    @(posedge Clk); #1;
    bus.Start    = 1'b1;
    bus.FirstReg = AW'(first);
    bus.LastReg  = AW'(last);
    @(posedge Clk); #1;
    bus.Start    = 1'b0;
    bus.FirstReg = AW'($urandom);
    bus.LastReg  = AW'($urandom);
  endtask

  task automatic waitValid();
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge Clk);
      seen = bus.OutValid;
    end
    check("valid_seen", seen, 1'b1);
  endtask

  task automatic waitDone(input logic [DW-1:0] sum);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge Clk);
      seen = bus.Done;
    end
    check("done_seen", seen, 1'b1);
    check("checksum", bus.Checksum, sum);
    @(negedge Clk);
    check("idle_after_done", {bus.Busy, bus.OutValid}, 2'b00);
    check("checksum_held", bus.Checksum, sum);
  endtask

  task automatic randomizeRegs();
    for (int i = 0; i < NREG; i++) regs[i] = $urandom;
  endtask

  initial begin
    logic [DW-1:0] sum;
    logic [DW-1:0] firstWord;
    logic [DW-1:0] heldData;
    logic [AW-1:0] heldAddr;
    int            doneBefore;

    randomizeRegs();
    Reset        = 1'b1;
    bus.Start    = 1'b0;
    bus.Abort    = 1'b0;
    bus.FirstReg = '0;
    bus.LastReg  = '0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("reset_state",
          {bus.OutValid, bus.Busy, bus.Done, bus.Checksum, bus.OutData, bus.OutAddr,
           bus.ReadRegister},
          '0);

    // Directed timing: r1..r3 = 0x11,0x22,0x44, Start presented in cycle 0
    regs[1] = 32'h11;
    regs[2] = 32'h22;
    regs[3] = 32'h44;
    pushExp(1, 3, sum);
    @(posedge Clk); #1;
    bus.Start    = 1'b1;
    bus.FirstReg = 5'd1;
    bus.LastReg  = 5'd3;
    for (int k = 0; k <= 8; k++) begin
      @(negedge Clk);
      check($sformatf("t_valid_c%0d", k), bus.OutValid, (k == 2 || k == 4 || k == 6));
      check($sformatf("t_done_c%0d", k), bus.Done, (k == 7));
      check($sformatf("t_busy_c%0d", k), bus.Busy, (k >= 1 && k <= 7));
      if (k == 1) begin
        bus.Start    = 1'b0;
        bus.FirstReg = AW'($urandom);
        bus.LastReg  = AW'($urandom);
      end
    end
    check("t_checksum", bus.Checksum, 32'h77);

    // Wrapping range 30 -> 1
    randomizeRegs();
    startDump(30, 1, sum);
    waitDone(sum);

    // Back-pressure on the first SEND
    readyMode = 2;
    startDump(7, 9, sum);
    waitValid();
    heldData = bus.OutData;
    heldAddr = bus.OutAddr;
    check("bp_first_addr", heldAddr, 5'd7);
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      check("bp_held", {bus.OutValid, bus.OutAddr, bus.OutData}, {1'b1, heldAddr, heldData});
    end
    @(posedge Clk); #1 readyMode = 0;
    waitDone(sum);

    // Abort while the second word is stalled in SEND
    firstWord = regs[10];
    readyMode = 2;
    startDump(10, 20, sum);
    waitValid();
    @(posedge Clk); #1 readyMode = 0;
    @(posedge Clk); #1 readyMode = 2;
    waitValid();
    check("abort_second_addr", bus.OutAddr, 5'd11);
    doneBefore = doneCount;
    @(posedge Clk); #1 bus.Abort = 1'b1;
    @(posedge Clk); #1 bus.Abort = 1'b0;
    @(negedge Clk);
    check("abort_idle", {bus.Busy, bus.OutValid, bus.Done}, 3'b000);
    check("abort_checksum", bus.Checksum, firstWord);
    expQ.delete();
    repeat (5) @(negedge Clk);
    check("abort_no_done", doneCount, doneBefore);
    readyMode = 0;

    // Reset in the middle of a full-range dump, then a single-word dump
    readyMode = 1;
    randomizeRegs();
    startDump(0, 31, sum);
    repeat (9) @(posedge Clk);
    #1 Reset = 1'b1;
    doneBefore = doneCount;
    @(posedge Clk); #1 Reset = 1'b0;
    expQ.delete();
    @(negedge Clk);
    check("midreset_state",
          {bus.OutValid, bus.Busy, bus.Done, bus.Checksum, bus.OutData, bus.OutAddr,
           bus.ReadRegister},
          '0);
    repeat (5) @(negedge Clk);
    check("midreset_no_done", {bus.Busy, 32'(doneCount)}, {1'b0, 32'(doneBefore)});
    readyMode = 0;
    startDump(5, 5, sum);
    waitDone(sum);

    // Start pulsed while busy must not disturb the running dump
    startDump(4, 9, sum);
    repeat (3) @(posedge Clk);
    #1;
    bus.Start    = 1'b1;
    bus.FirstReg = 5'd20;
    bus.LastReg  = 5'd25;
    @(posedge Clk); #1 bus.Start = 1'b0;
    waitDone(sum);
    repeat (3) begin
      @(negedge Clk);
      check("no_restart", bus.Busy, 1'b0);
    end

    // Random ranges under random back-pressure
    readyMode = 1;
    for (int r = 0; r < 6; r++) begin
      randomizeRegs();
      startDump(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), sum);
      waitDone(sum);
    end
    readyMode = 0;
    repeat (2) @(negedge Clk);
    check("queue_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
